// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_write_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  // Smallest id width able to name n requesters (at least one bit).
  function automatic int unsigned id_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Rotate-priority encoder: first asserted request at or after ptr, wrapping.
module reg_write_arbiter_rr_pick
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid_c,
  output logic [IDW-1:0]  winner_c
);

  logic [IDW-1:0] idx;

  // Scan farthest-to-nearest so the candidate closest to ptr wins last.
  always_comb begin
    valid_c  = |req;
    winner_c = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(ptr) + NREQ - 1 - k) % NREQ);
      if (req[idx]) winner_c = idx;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter driving the enable/data inputs of one shared register,
// with optional locked bursts of up to MAX_BURST beats per grant.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned N         = 64,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned IDW       = id_width(NREQ),
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              R,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*N-1:0] wdata,
  output logic              E,
  output logic [N-1:0]      data,
  output logic [NREQ-1:0]   ack,
  output logic [IDW-1:0]    gnt_id,
  output logic              busy
);

  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic              e_q, e_d;
  logic [N-1:0]      data_q, data_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [IDW-1:0]    gnt_id_q, gnt_id_d;
  logic              busy_q, busy_d;

  logic              pick_valid_c;
  logic [IDW-1:0]    pick_id_c;
  logic              cont_c;
  logic [IDW-1:0]    ptr_next_c;

  reg_write_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req      (req),
    .ptr      (ptr_q),
    .valid_c  (pick_valid_c),
    .winner_c (pick_id_c)
  );

  // Holder keeps the register only while it asks, locks, and has beats left.
  assign cont_c     = lock[gnt_id_q] && req[gnt_id_q] && (bcnt_q < BCW'(MAX_BURST));
  assign ptr_next_c = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    bcnt_d   = bcnt_q;
    e_d      = 1'b0;
    ack_d    = '0;
    data_d   = data_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          data_d   = wdata[pick_id_c*N +: N];
          e_d      = 1'b1;
          ack_d    = NREQ'(1'b1) << pick_id_c;
          gnt_id_d = pick_id_c;
          bcnt_d   = BCW'(1);
          busy_d   = 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (cont_c) begin
          data_d = wdata[gnt_id_q*N +: N];
          e_d    = 1'b1;
          ack_d  = NREQ'(1'b1) << gnt_id_q;
          bcnt_d = bcnt_q + BCW'(1);
        end else begin
          busy_d  = 1'b0;
          ptr_d   = ptr_next_c;
          bcnt_d  = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      bcnt_q   <= '0;
      e_q      <= 1'b0;
      data_q   <= '0;
      ack_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      bcnt_q   <= bcnt_d;
      e_q      <= e_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
    end
  end

  assign E      = e_q;
  assign data   = data_q;
  assign ack    = ack_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: directed request scripts queue the
// expected writes (id, data, cycle); a monitor checks every cycle of output.
module tb_reg_write_arbiter;

  localparam int unsigned N    = 64;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              CLK = 1'b0;
  logic              R;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   lock;
  logic [NREQ*N-1:0] wdata;
  logic              E;
  logic [N-1:0]      data;
  logic [NREQ-1:0]   ack;
  logic [IDW-1:0]    gnt_id;
  logic              busy;

  typedef struct {
    int          id;
    logic [63:0] d;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   b;

  reg_write_arbiter #(
    .N         (N),
    .NREQ      (NREQ),
    .IDW       (IDW),
    .MAX_BURST (4)
  ) dut (
    .CLK    (CLK),
    .R      (R),
    .req    (req),
    .lock   (lock),
    .wdata  (wdata),
    .E      (E),
    .data   (data),
    .ack    (ack),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every write must match the head of the scoreboard, including its cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (!R) begin
      if (E) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write cyc=%0d ack=%b gnt_id=%0d data=%h", cyc, ack, gnt_id, data);
        end else begin
          e = exp_q.pop_front();
          if (ack !== 4'(1 << e.id) || data !== e.d || gnt_id !== 2'(e.id) ||
              busy !== 1'b1 || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL write_beat: got cyc=%0d ack=%b gnt_id=%0d busy=%b data=%h, expected cyc=%0d id=%0d busy=1 data=%h",
                     cyc, ack, gnt_id, busy, data, e.cyc, e.id, e.d);
          end
        end
      end else begin
        vectors++;
        if (ack !== '0) begin
          miscompares++;
          $display("FAIL ack_without_E cyc=%0d: got ack=%b expected 0000", cyc, ack);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic [3:0] r, input logic [3:0] l);
    req  = r;
    lock = l;
    @(negedge CLK);
  endtask

  task automatic set_wd(input int i, input logic [63:0] v);
    wdata[i*N +: N] = v;
  endtask

  task automatic expect_wr(input int id, input logic [63:0] d, input int c);
    exp_t e;
    e.id  = id;
    e.d   = d;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic do_reset();
    R = 1'b1;
    req = '0;
    lock = '0;
    @(negedge CLK);
    R = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    R = 1'b1;
    req = '0;
    lock = '0;
    wdata = '0;
    #3;
    check("reset_E", 64'(E), 64'd0);
    check("reset_ack", 64'(ack), 64'd0);
    check("reset_data", data, 64'd0);
    check("reset_gnt_id", 64'(gnt_id), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    R = 1'b0;
    repeat (3) @(negedge CLK);

    // Single write from id2, then registered outputs hold while idle.
    b = cyc;
    set_wd(2, 64'hDEAD_BEEF_0123_4567);
    expect_wr(2, 64'hDEAD_BEEF_0123_4567, b + 1);
    step(4'b0100, 4'b0000);
    step(4'b0100, 4'b0000);
    step(4'b0000, 4'b0000);
    check("idle_E", 64'(E), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_gnt_id_hold", 64'(gnt_id), 64'd2);
    check("idle_data_hold", data, 64'hDEAD_BEEF_0123_4567);
    step(4'b0000, 4'b0000);

    // Pointer is now 3: id3 beats id0.
    b = cyc;
    set_wd(0, 64'h0000_0000_0000_00A0);
    set_wd(3, 64'h0000_0000_0000_00A3);
    expect_wr(3, 64'h0000_0000_0000_00A3, b + 1);
    expect_wr(0, 64'h0000_0000_0000_00A0, b + 3);
    step(4'b1001, 4'b0000);
    step(4'b1001, 4'b0000);
    step(4'b0001, 4'b0000);
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // Round-robin from ptr=0 with all requesters active.
    do_reset();
    b = cyc;
    for (int i = 0; i < 4; i++) set_wd(i, 64'h5555_0000_0000_0000 + 64'(i));
    expect_wr(0, 64'h5555_0000_0000_0000, b + 1);
    expect_wr(1, 64'h5555_0000_0000_0001, b + 3);
    expect_wr(2, 64'h5555_0000_0000_0002, b + 5);
    expect_wr(3, 64'h5555_0000_0000_0003, b + 7);
    expect_wr(0, 64'h5555_0000_0000_0000, b + 9);
    repeat (9) step(4'b1111, 4'b0000);
    repeat (2) step(4'b0000, 4'b0000);

    // Burst cap: id1 locked for 10 cycles gives 4 beats, a bubble, 4 beats.
    b = cyc;
    for (int j = 1; j <= 4; j++) expect_wr(1, 64'hB000_0000_0000_0000 + 64'(j - 1), b + j);
    for (int j = 6; j <= 9; j++) expect_wr(1, 64'hB000_0000_0000_0000 + 64'(j - 1), b + j);
    for (int k = 0; k < 10; k++) begin
      set_wd(1, 64'hB000_0000_0000_0000 + 64'(k));
      step(4'b0010, 4'b0010);
    end
    repeat (2) step(4'b0000, 4'b0000);

    // Locked id0 yields to id1 after 4 beats, then regains the register.
    b = cyc;
    set_wd(0, 64'h0000_0000_0000_00C0);
    set_wd(1, 64'h0000_0000_0000_00C1);
    for (int j = 1; j <= 4; j++) expect_wr(0, 64'h0000_0000_0000_00C0, b + j);
    expect_wr(1, 64'h0000_0000_0000_00C1, b + 6);
    for (int j = 8; j <= 10; j++) expect_wr(0, 64'h0000_0000_0000_00C0, b + j);
    repeat (7) step(4'b0011, 4'b0001);
    repeat (3) step(4'b0001, 4'b0001);
    repeat (2) step(4'b0000, 4'b0000);

    // id3 pulses during id0's grant and is never served; ptr ends at 1.
    b = cyc;
    set_wd(0, 64'h0000_0000_0000_00D0);
    set_wd(1, 64'h0000_0000_0000_00D1);
    set_wd(3, 64'h0000_0000_0000_00D3);
    expect_wr(0, 64'h0000_0000_0000_00D0, b + 1);
    expect_wr(0, 64'h0000_0000_0000_00D0, b + 2);
    expect_wr(1, 64'h0000_0000_0000_00D1, b + 6);
    expect_wr(0, 64'h0000_0000_0000_00D0, b + 8);
    step(4'b0001, 4'b0001);
    step(4'b1001, 4'b0001);
    repeat (3) step(4'b0000, 4'b0000);
    repeat (2) step(4'b0011, 4'b0000);
    repeat (2) step(4'b0001, 4'b0000);
    repeat (2) step(4'b0000, 4'b0000);

    // Asynchronous reset in the middle of a locked burst.
    b = cyc;
    expect_wr(1, 64'h0000_0000_0000_00D1, b + 1);
    expect_wr(1, 64'h0000_0000_0000_00D1, b + 2);
    step(4'b1111, 4'b1111);
    step(4'b1111, 4'b1111);
    #2;
    R = 1'b1;
    #1;
    check("async_rst_E", 64'(E), 64'd0);
    check("async_rst_ack", 64'(ack), 64'd0);
    check("async_rst_data", data, 64'd0);
    check("async_rst_gnt_id", 64'(gnt_id), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    req = '0;
    lock = '0;
    @(negedge CLK);
    R = 1'b0;
    repeat (4) @(negedge CLK);
    check("post_rst_E", 64'(E), 64'd0);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_writes: got %0d unserved expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
